core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Parametrised run-control and memory-port arbiter between the processor core and NUM_EXT external memory masters (serial loader, debug bench, DMA). It owns the core clock enable and implements halt, single-step and resume with a clean drain, replacing the single hard-wired pause/external-control mux. While the core is halted, it grants the unified memory port to external masters one access at a time, round-robin.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- NUM_EXT, 2, number of external masters (1..8)
- START_HALTED, 0, 1 = leave reset in HALTED instead of RUN

Ports:
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous, active-low reset
- halt_req  in  1  level; core must stop and stay stopped while high
- step_req  in  1  one-cycle pulse; execute exactly one instruction while halted
- core_en  out  1  clock enable to PC, register file and branch delay flops
- halted  out  1  high in HALTED, EXT_ACCESS and EXT_RESP
- retired_count  out  32  instructions executed (core_en cycles); wraps
- core_addr / core_wdata  in  ADDR_W / DATA_W  core data-port request
- core_read_mode / core_write_mode  in  3 / 3  core access modes (0 = none)
- core_rdata  out  DATA_W  mem_rdata forwarded to the core
- ext_req  in  NUM_EXT  per-master request level
- ext_addr / ext_wdata  in  NUM_EXT*ADDR_W / NUM_EXT*DATA_W  flattened, master i at slice i
- ext_read_mode / ext_write_mode  in  NUM_EXT*3 each  flattened modes
- ext_gnt  out  NUM_EXT  one-hot grant
- ext_rvalid  out  NUM_EXT  one-hot read-data strobe
- ext_rdata  out  DATA_W  shared read data, valid with ext_rvalid
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  to memory
- mem_read_mode / mem_write_mode  out  3 / 3  to memory
- mem_rdata  in  DATA_W  memory read data, one-cycle synchronous latency

## Operation
- States: RUN, DRAIN, HALTED, STEP, EXT_ACCESS, EXT_RESP.
- RUN: core_en = 1; memory port is driven by core_*. Goes to DRAIN if halt_req or any ext_req.
- DRAIN: core_en = 0; port stays with the core, with modes forced to 0, so the final core read completes. Always goes to HALTED next cycle.
- HALTED: core_en = 0. Priority of exits:
  - any ext_req -> EXT_ACCESS with the round-robin winner;
  - else step_req -> STEP;
  - else !halt_req -> RUN.
- STEP: core_en = 1 for one cycle, port owned by the core, then HALTED. halt_req is ignored in this state. If halt_req is low, the next HALTED cycle resumes RUN.
- EXT_ACCESS: ext_gnt[w] = 1. mem_* is driven by master w's slice. Then EXT_RESP.
- EXT_RESP: ext_rvalid[w] = 1 and ext_rdata = mem_rdata, also for writes (the master ignores it). mem modes are 0. Then HALTED.
- Round-robin: the winner is the first requesting index after last_gnt, cyclic. last_gnt resets to NUM_EXT-1, so master 0 wins first.
- In every state not owned by a master, mem modes = 0 and mem_addr/mem_wdata = 0. core_rdata = mem_rdata always.
- retired_count increments in every cycle with core_en = 1 (RUN, STEP), modulo 2^32.

## Timing
- Reset values:
  - state RUN, or HALTED if START_HALTED;
  - core_en = !START_HALTED, halted = START_HALTED;
  - ext_gnt, ext_rvalid, retired_count, last_gnt-relative grant all 0;
  - mem_*: core pass-through if RUN, else 0.
- core_en, halted, ext_gnt and ext_rvalid are decoded from registered state, so they are glitch-free. mem_* is a combinational mux on registered state.
- Halt latency: request sampled at cycle N gives core_en = 0 from cycle N+1, and halted = 1 from N+2.
- External access: 4 cycles from req to rvalid when running (RUN->DRAIN->HALTED->ACCESS->RESP). When already halted, rvalid arrives 2 cycles after the HALTED sample.
- Masters hold their slice stable while ext_req = 1 and may drop req in the cycle after gnt. A request still high after RESP is re-arbitrated; it gets no back-to-back grant while another master is requesting.
- Simultaneous ext_req and step_req in HALTED: ext wins and the step pulse is dropped.
- step_req outside HALTED is ignored.
- Reset asserted mid-access: everything returns to reset values immediately; no rvalid is issued.

## Test plan
- Reset with START_HALTED=0 -> core_en=1, retired_count counts 1,2,3…; assert halt_req at count 10 -> core_en low next cycle, count frozen at 11, halted after one further cycle.
- Halted, pulse step_req three times, 5 cycles apart -> retired_count +3, exactly one core_en cycle per pulse.
- Halted, master 0 writes 0xDEADBEEF to 0x40 (write mode 3), then master 1 reads 0x40 -> ext_rvalid[1] with ext_rdata = 0xDEADBEEF, and no gnt overlap.
- Both masters hold req continuously for 6 grants -> grants alternate 0,1,0,1,0,1.
- While RUN, ext_req[1] with halt_req = 0 -> core stops, access served, core returns to RUN with the count continuous.
- Assert rst during EXT_ACCESS -> ext_gnt and ext_rvalid drop immediately, state RUN, count 0.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Run-control and memory-port arbiter: owns the core clock enable (halt / step / resume)
// and, while the core is halted, grants the memory port round-robin to external masters.
module core_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NUM_EXT      = 2,
  parameter int START_HALTED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      halt_req,
  input  logic                      step_req,
  output logic                      core_en,
  output logic                      halted,
  output logic [31:0]               retired_count,
  input  logic [ADDR_W-1:0]         core_addr,
  input  logic [DATA_W-1:0]         core_wdata,
  input  logic [2:0]                core_read_mode,
  input  logic [2:0]                core_write_mode,
  output logic [DATA_W-1:0]         core_rdata,
  input  logic [NUM_EXT-1:0]        ext_req,
  input  logic [NUM_EXT*ADDR_W-1:0] ext_addr,
  input  logic [NUM_EXT*DATA_W-1:0] ext_wdata,
  input  logic [NUM_EXT*3-1:0]      ext_read_mode,
  input  logic [NUM_EXT*3-1:0]      ext_write_mode,
  output logic [NUM_EXT-1:0]        ext_gnt,
  output logic [NUM_EXT-1:0]        ext_rvalid,
  output logic [DATA_W-1:0]         ext_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [2:0]                mem_read_mode,
  output logic [2:0]                mem_write_mode,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [2:0]                dbgState
);

  localparam int IDX_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    DRAIN      = 3'd1,
    HALT       = 3'd2,
    STEP       = 3'd3,
    EXT_ACCESS = 3'd4,
    EXT_RESP   = 3'd5
  } state_t;

  localparam state_t RESET_STATE = (START_HALTED != 0) ? HALT : RUN;

  state_t           state;
  state_t           nextState;
  logic [IDX_W-1:0] lastGnt;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] hiIdx;
  logic [IDX_W-1:0] loIdx;
  logic             hiFound;
  logic             anyReq;

  assign anyReq   = |ext_req;
  assign dbgState = state;

  // Round-robin: lowest requester above lastGnt, otherwise wrap to the lowest requester.
  always_comb begin
    hiFound = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (ext_req[i]) begin
        if (i > int'(lastGnt)) begin
          hiFound = 1'b1;
          hiIdx   = IDX_W'(i);
        end else begin
          loIdx = IDX_W'(i);
        end
      end
    end
    winner = hiFound ? hiIdx : loIdx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET_STATE;
    end else begin
      state <= nextState;
    end
  end

  // lastGnt doubles as the index of the master currently owning the port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGnt <= IDX_W'(NUM_EXT - 1);
    end else if (state == HALT && anyReq) begin
      lastGnt <= winner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_count <= 32'd0;
    end else if (core_en) begin
      retired_count <= retired_count + 32'd1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN:        if (halt_req || anyReq) nextState = DRAIN;
      DRAIN:      nextState = HALT;
      HALT: begin
        if (anyReq)         nextState = EXT_ACCESS;
        else if (step_req)  nextState = STEP;
        else if (!halt_req) nextState = RUN;
      end
      STEP:       nextState = HALT;
      EXT_ACCESS: nextState = EXT_RESP;
      EXT_RESP:   nextState = HALT;
      default:    nextState = RESET_STATE;
    endcase
  end

  always_comb begin
    core_en        = 1'b0;
    halted         = 1'b0;
    ext_gnt        = '0;
    ext_rvalid     = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_read_mode  = 3'd0;
    mem_write_mode = 3'd0;
    case (state)
      RUN, STEP: begin
        core_en        = 1'b1;
        mem_addr       = core_addr;
        mem_wdata      = core_wdata;
        mem_read_mode  = core_read_mode;
        mem_write_mode = core_write_mode;
      end
      // The core keeps the port so its last read lands, but no new access starts.
      DRAIN: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      HALT: halted = 1'b1;
      EXT_ACCESS: begin
        halted           = 1'b1;
        ext_gnt[lastGnt] = 1'b1;
        mem_addr         = ext_addr[lastGnt*ADDR_W +: ADDR_W];
        mem_wdata        = ext_wdata[lastGnt*DATA_W +: DATA_W];
        mem_read_mode    = ext_read_mode[lastGnt*3 +: 3];
        mem_write_mode   = ext_write_mode[lastGnt*3 +: 3];
      end
      EXT_RESP: begin
        halted              = 1'b1;
        ext_rvalid[lastGnt] = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_rdata = mem_rdata;
  assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: run/halt/step timing, external accesses against a
// reference memory, round-robin ordering and asynchronous reset mid-access.
module tb_core_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_EXT = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      halt_req = 1'b0;
  logic                      step_req = 1'b0;
  logic                      core_en;
  logic                      halted;
  logic [31:0]               retired_count;
  logic [ADDR_W-1:0]         core_addr = '0;
  logic [DATA_W-1:0]         core_wdata = '0;
  logic [2:0]                core_read_mode = 3'd0;
  logic [2:0]                core_write_mode = 3'd0;
  logic [DATA_W-1:0]         core_rdata;
  logic [NUM_EXT-1:0]        ext_req = '0;
  logic [NUM_EXT*ADDR_W-1:0] ext_addr = '0;
  logic [NUM_EXT*DATA_W-1:0] ext_wdata = '0;
  logic [NUM_EXT*3-1:0]      ext_read_mode = '0;
  logic [NUM_EXT*3-1:0]      ext_write_mode = '0;
  logic [NUM_EXT-1:0]        ext_gnt;
  logic [NUM_EXT-1:0]        ext_rvalid;
  logic [DATA_W-1:0]         ext_rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [2:0]                mem_read_mode;
  logic [2:0]                mem_write_mode;
  logic [DATA_W-1:0]         mem_rdata = '0;
  logic [2:0]                dbgState;

  core_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_EXT(NUM_EXT), .START_HALTED(0)
  ) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .step_req(step_req),
    .core_en(core_en), .halted(halted), .retired_count(retired_count),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_read_mode(core_read_mode), .core_write_mode(core_write_mode),
    .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_read_mode(ext_read_mode), .ext_write_mode(ext_write_mode),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_mode(mem_read_mode), .mem_write_mode(mem_write_mode),
    .mem_rdata(mem_rdata), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Memory with one-cycle synchronous read; only the low 1 KiB window is backed.
  logic [DATA_W-1:0] sim_mem [0:255];
  always @(posedge clk) begin
    if (mem_write_mode != 3'd0 && mem_addr[31:10] == 22'd0)
      sim_mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_read_mode != 3'd0)
      mem_rdata <= (mem_addr[31:10] == 22'd0) ? sim_mem[mem_addr[9:2]] : '0;
  end

  // scoreboard
  logic [DATA_W-1:0] ref_mem [0:255];
  logic [DATA_W-1:0] exp_q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                rr_last = NUM_EXT - 1;
  int                exp_count = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one external access by master m, expecting the grant after exp_lat cycles
  task automatic ext_access(input int m, input bit wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int exp_lat);
    int waited;
    bit got;
    ext_addr[m*ADDR_W +: ADDR_W]  = a;
    ext_wdata[m*DATA_W +: DATA_W] = d;
    ext_write_mode[m*3 +: 3]      = wr ? 3'd3 : 3'd0;
    ext_read_mode[m*3 +: 3]       = wr ? 3'd0 : 3'd3;
    ext_req[m]                    = 1'b1;
    if (!wr) exp_q.push_back(ref_mem[a[9:2]]);
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 20) begin
      tick();
      waited++;
      if (ext_gnt != '0) got = 1'b1;
    end
    check_eq("gnt_seen", got, 1);
    if (got) begin
      rr_last = m;
      check_eq("gnt_onehot", ext_gnt, 1 << m);
      check_eq("gnt_latency", waited, exp_lat);
      check_eq("gnt_mem_addr", mem_addr, a);
      check_eq("gnt_mem_wmode", mem_write_mode, wr ? 3 : 0);
      tick();
      check_eq("rvalid_onehot", ext_rvalid, 1 << m);
      check_eq("gnt_dropped", ext_gnt, 0);
      check_eq("resp_mem_modes", {mem_read_mode, mem_write_mode}, 0);
      if (wr) ref_mem[a[9:2]] = d;
      else if (exp_q.size() > 0) check_eq("ext_rdata", ext_rdata, exp_q.pop_front());
    end
    ext_req[m]               = 1'b0;
    ext_write_mode[m*3 +: 3] = 3'd0;
    ext_read_mode[m*3 +: 3]  = 3'd0;
    tick();
  endtask

  initial begin
    int ones;
    int waited;
    bit got;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    for (int i = 0; i < 256; i++) begin
      sim_mem[i] = '0;
      ref_mem[i] = '0;
    end
    core_addr       = 32'hF000_0000 | $urandom;
    core_wdata      = $urandom;
    core_read_mode  = 3'd2;
    core_write_mode = 3'd3;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_core_en", core_en, 1);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_gnt", ext_gnt, 0);
    check_eq("rst_rvalid", ext_rvalid, 0);
    check_eq("rst_count", retired_count, 0);
    check_eq("rst_mem_addr", mem_addr, core_addr);
    check_eq("rst_mem_modes", {mem_read_mode, mem_write_mode}, {core_read_mode, core_write_mode});
    rst = 1'b1;

    // free-running count, then halt at count 10
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_count++;
      check_eq("run_count", retired_count, exp_count);
    end
    halt_req = 1'b1;
    tick();
    exp_count++;
    check_eq("drain_core_en", core_en, 0);
    check_eq("drain_halted", halted, 0);
    check_eq("drain_count", retired_count, 11);
    check_eq("drain_mem_modes", {mem_read_mode, mem_write_mode}, 0);
    tick();
    check_eq("halt_halted", halted, 1);
    check_eq("halt_core_en", core_en, 0);
    check_eq("halt_count", retired_count, exp_count);
    check_eq("halt_mem_addr", mem_addr, 0);

    // three single steps, 5 cycles apart
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      ones = 0;
      for (int c = 0; c < 5; c++) begin
        tick();
        step_req = 1'b0;
        if (core_en) ones++;
      end
      check_eq("step_one_cycle", ones, 1);
      exp_count++;
    end
    check_eq("step_count", retired_count, exp_count);

    // directed write then read across masters, then random accesses
    ext_access(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1);
    ext_access(1, 1'b0, 32'h40, 32'h0, 1);
    for (int k = 0; k < 10; k++) begin
      a = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      ext_access($urandom_range(0, NUM_EXT - 1), 1'($urandom_range(0, 1)), a, d, 1);
    end
    check_eq("ext_count_frozen", retired_count, exp_count);

    // both masters request continuously: grants rotate
    for (int m = 0; m < NUM_EXT; m++) begin
      ext_addr[m*ADDR_W +: ADDR_W] = 32'h40;
      ext_read_mode[m*3 +: 3]      = 3'd3;
    end
    ext_req = '1;
    for (int g = 0; g < 6; g++) begin
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 20) begin
        tick();
        waited++;
        if (ext_gnt != '0) got = 1'b1;
      end
      check_eq("rr_gnt_seen", got, 1);
      rr_last = (rr_last + 1) % NUM_EXT;
      check_eq("rr_order", ext_gnt, 1 << rr_last);
      tick();
      if (g == 5) ext_req = '0;
      check_eq("rr_rvalid", ext_rvalid, 1 << rr_last);
      check_eq("rr_rdata", ext_rdata, ref_mem[16]);
    end
    ext_read_mode = '0;
    tick();

    // resume, then an external access taken from RUN
    halt_req = 1'b0;
    tick();
    check_eq("resume_core_en", core_en, 1);
    check_eq("resume_count", retired_count, exp_count);
    repeat (3) begin
      tick();
      exp_count++;
    end
    check_eq("resume_run_count", retired_count, exp_count);
    exp_count++;
    ext_access(1, 1'b0, 32'h40, 32'h0, 3);
    tick();
    check_eq("back_to_run", core_en, 1);
    check_eq("count_continuous", retired_count, exp_count);
    tick();
    exp_count++;
    check_eq("count_after_resume", retired_count, exp_count);

    // reset asserted during EXT_ACCESS
    ext_addr[0 +: ADDR_W] = 32'h80;
    ext_read_mode[0 +: 3] = 3'd3;
    ext_req[0]            = 1'b1;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 20) begin
      tick();
      waited++;
      if (ext_gnt != '0) got = 1'b1;
    end
    check_eq("rst_mid_gnt_seen", got, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_mid_gnt", ext_gnt, 0);
    check_eq("rst_mid_rvalid", ext_rvalid, 0);
    check_eq("rst_mid_core_en", core_en, 1);
    check_eq("rst_mid_halted", halted, 0);
    check_eq("rst_mid_count", retired_count, 0);
    ext_req       = '0;
    ext_read_mode = '0;
    tick();
    check_eq("rst_hold_rvalid", ext_rvalid, 0);
    rst = 1'b1;
    tick();
    check_eq("post_rst_count", retired_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
